// File: rtl/inst_mem_resp_if.sv
// Fetch request/response, plus the program-load write port, between a requester and inst_mem_resp.
// All signals are 32-bit address/data or 1-bit strobes; the interface is unparameterised.
interface inst_mem_resp_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_inst;
    logic        resp_err;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;

    modport master (
        output req_valid, req_addr, resp_ready, ld_en, ld_addr, ld_data,
        input  req_ready, resp_valid, resp_inst, resp_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready, ld_en, ld_addr, ld_data,
        output req_ready, resp_valid, resp_inst, resp_err
    );
endinterface

// File: rtl/inst_mem_resp.sv
// Instruction memory responder: one outstanding fetch, loadable word array, IDLE/WAIT/RESP FSM.
// resp_valid comes LATENCY cycles after accept; the response is held until resp_ready, and req_ready is high only in IDLE.
// IMEM_BOUNDS_CHECK_EN adds misaligned/out-of-range fault responses and drops out-of-range loads.
module inst_mem_resp #(
    parameter int DEPTH_LOG2 = 6,
    parameter int LATENCY    = 2
) (
    input  logic           clk,
    input  logic           reset,
    inst_mem_resp_if.slave bus
);
    localparam int          DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [31:0] EBREAK   = 32'h0010_0073;
    localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_next;
    logic [31:0]           r_addr;
    logic [31:0]           r_inst;
    logic                  r_err;
    logic [31:0]           r_mem [DEPTH];

    logic                  w_accept;
    logic                  w_enter_resp;
    logic [31:0]           w_fetch_addr;
    logic [DEPTH_LOG2-1:0] w_rd_idx;
    logic [DEPTH_LOG2-1:0] w_ld_idx;
    logic                  w_rd_bad;
    logic                  w_ld_ok;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_next     = (LATENCY == 1) ? RESP : WAIT;
                    w_cnt_next = CNT_INIT;
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = RESP;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_accept     = (r_state == IDLE) && bus.req_valid;
    assign w_enter_resp = (w_next == RESP) && (r_state != RESP);

    // With LATENCY=1 the RESP-entry read happens on the accept edge, before r_addr is loaded.
    assign w_fetch_addr = (r_state == IDLE) ? bus.req_addr : r_addr;
    assign w_rd_idx     = w_fetch_addr[DEPTH_LOG2+1:2];
    assign w_ld_idx     = bus.ld_addr[DEPTH_LOG2+1:2];

`ifdef IMEM_BOUNDS_CHECK_EN
    assign w_rd_bad = (w_fetch_addr[1:0] != 2'b00) || (w_fetch_addr[31:DEPTH_LOG2+2] != '0);
    assign w_ld_ok  = (bus.ld_addr[31:DEPTH_LOG2+2] == '0);
`else
    assign w_rd_bad = 1'b0;
    assign w_ld_ok  = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 32'h0;
            r_inst  <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_addr <= bus.req_addr;
            end
            if (w_enter_resp) begin
                r_inst <= w_rd_bad ? EBREAK : r_mem[w_rd_idx];
                r_err  <= w_rd_bad;
            end
        end
    end

    // Memory is not reset; a same-edge load and fetch read see the old word.
    always_ff @(posedge clk) begin
        if (bus.ld_en && w_ld_ok) begin
            r_mem[w_ld_idx] <= bus.ld_data;
        end
    end

    assign bus.req_ready  = (r_state == IDLE);
    assign bus.resp_valid = (r_state == RESP);
    assign bus.resp_inst  = r_inst;
    assign bus.resp_err   = r_err;
endmodule

// File: tb/tb_inst_mem_resp.sv
// Directed bench for inst_mem_resp: a LATENCY=2 instance for the main table and corner cases,
// and a LATENCY=1 instance for back-to-back throughput.
module tb_inst_mem_resp;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t vt [7];

    always #5 clk = ~clk;

    inst_mem_resp_if ia ();
    inst_mem_resp_if ib ();

    inst_mem_resp #(.DEPTH_LOG2(6), .LATENCY(2)) u_dut_a (.clk(clk), .reset(reset), .bus(ia));
    inst_mem_resp #(.DEPTH_LOG2(6), .LATENCY(1)) u_dut_b (.clk(clk), .reset(reset), .bus(ib));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load(input logic [31:0] addr, input logic [31:0] data, input logic both);
        @(negedge clk);
        ia.ld_en = 1'b1; ia.ld_addr = addr; ia.ld_data = data;
        if (both) begin
            ib.ld_en = 1'b1; ib.ld_addr = addr; ib.ld_data = data;
        end
        @(negedge clk);
        ia.ld_en = 1'b0;
        ib.ld_en = 1'b0;
    endtask

    task automatic fetch_a(input logic [31:0] addr, output logic [31:0] inst, output logic err,
                           output int lat);
        @(negedge clk);
        ia.req_valid = 1'b1; ia.req_addr = addr; ia.resp_ready = 1'b1;
        @(negedge clk);
        ia.req_valid = 1'b0;
        lat = 1;
        while (!ia.resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        inst = ia.resp_inst;
        err  = ia.resp_err;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] inst;
        logic        err;
        int          lat;
        int          t;
        logic        ok_v, ok_i, ok_r, seen;

        vt[0] = '{32'h0000_0000, 32'h0050_0093, 1'b0};
        vt[1] = '{32'h0000_0004, 32'hAAAA_0001, 1'b0};
        vt[2] = '{32'h0000_000C, 32'h1234_5678, 1'b0};
        vt[3] = '{32'h0000_00FC, 32'hDEAD_BEEF, 1'b0};
`ifdef IMEM_BOUNDS_CHECK_EN
        vt[4] = '{32'h0000_0100, EBREAK,        1'b1};
        vt[5] = '{32'h0000_0002, EBREAK,        1'b1};
        vt[6] = '{32'h0000_010C, EBREAK,        1'b1};
`else
        vt[4] = '{32'h0000_0100, 32'h0050_0093, 1'b0};
        vt[5] = '{32'h0000_0002, 32'h0050_0093, 1'b0};
        vt[6] = '{32'h0000_010C, 32'h1234_5678, 1'b0};
`endif

        ia.req_valid = 1'b0; ia.req_addr = '0; ia.resp_ready = 1'b1;
        ia.ld_en = 1'b0; ia.ld_addr = '0; ia.ld_data = '0;
        ib.req_valid = 1'b0; ib.req_addr = '0; ib.resp_ready = 1'b1;
        ib.ld_en = 1'b0; ib.ld_addr = '0; ib.ld_data = '0;
        reset = 1'b1;

        // Program load while reset is held: memory writes must still land.
        load(32'h0000_0000, 32'h0050_0093, 1'b1);
        load(32'h0000_0004, 32'hAAAA_0001, 1'b1);
        load(32'h0000_0008, 32'h1111_1111, 1'b0);
        load(32'h0000_000C, 32'h1234_5678, 1'b0);
        load(32'h0000_00FC, 32'hDEAD_BEEF, 1'b0);

        chk("reset req_ready",  ia.req_ready,  1);
        chk("reset resp_valid", ia.resp_valid, 0);
        chk("reset resp_inst",  ia.resp_inst,  0);
        chk("reset resp_err",   ia.resp_err,   0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            fetch_a(vt[i].addr, inst, err, lat);
            chk($sformatf("vec%0d inst", i),    inst, vt[i].inst);
            chk($sformatf("vec%0d err", i),     err,  vt[i].err);
            chk($sformatf("vec%0d latency", i), lat,  2);
        end

        // Response held under backpressure.
        @(negedge clk);
        ia.req_valid = 1'b1; ia.req_addr = 32'h4; ia.resp_ready = 1'b0;
        @(negedge clk);
        ia.req_valid = 1'b0;
        t = 0;
        while (!ia.resp_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("hold latency", t, 1);
        ok_v = 1'b1; ok_i = 1'b1; ok_r = 1'b1;
        for (int k = 0; k < 5; k++) begin
            ok_v &= ia.resp_valid;
            ok_i &= (ia.resp_inst == 32'hAAAA_0001);
            ok_r &= !ia.req_ready;
            @(negedge clk);
        end
        chk("hold resp_valid", ok_v, 1);
        chk("hold resp_inst",  ok_i, 1);
        chk("hold req_ready",  ok_r, 1);
        ia.resp_ready = 1'b1;
        @(negedge clk);
        chk("hold release valid", ia.resp_valid, 0);
        chk("hold release ready", ia.req_ready,  1);

        // Load to the same word on the RESP-entry edge returns the old contents.
        @(negedge clk);
        ia.req_valid = 1'b1; ia.req_addr = 32'h8;
        @(negedge clk);
        ia.req_valid = 1'b0;
        ia.ld_en = 1'b1; ia.ld_addr = 32'h8; ia.ld_data = 32'h2222_2222;
        @(negedge clk);
        ia.ld_en = 1'b0;
        chk("rbw valid", ia.resp_valid, 1);
        chk("rbw old word", ia.resp_inst, 32'h1111_1111);
        @(negedge clk);
        fetch_a(32'h8, inst, err, lat);
        chk("rbw new word", inst, 32'h2222_2222);

        // Out-of-range load: dropped with bounds checking, wraps onto word 1 without.
        load(32'h0000_0104, 32'h5555_5555, 1'b0);
        fetch_a(32'h4, inst, err, lat);
`ifdef IMEM_BOUNDS_CHECK_EN
        chk("oob load", inst, 32'hAAAA_0001);
`else
        chk("oob load", inst, 32'h5555_5555);
`endif

        // Reset one cycle after accept abandons the fetch.
        @(negedge clk);
        ia.req_valid = 1'b1; ia.req_addr = 32'h0;
        @(negedge clk);
        ia.req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        seen = ia.resp_valid;
        chk("abort inst cleared", ia.resp_inst, 0);
        @(negedge clk);
        chk("abort req_ready", ia.req_ready, 1);
        for (int k = 0; k < 10; k++) begin
            seen |= ia.resp_valid;
            @(negedge clk);
        end
        chk("abort no resp", seen, 0);

        // LATENCY=1 instance: back-to-back fetches, accepts two cycles apart.
        @(negedge clk);
        chk("l1 ready c0", ib.req_ready, 1);
        ib.req_valid = 1'b1; ib.req_addr = 32'h0; ib.resp_ready = 1'b1;
        @(negedge clk);
        chk("l1 valid c1", ib.resp_valid, 1);
        chk("l1 inst c1",  ib.resp_inst,  32'h0050_0093);
        chk("l1 ready c1", ib.req_ready,  0);
        ib.req_addr = 32'h4;
        @(negedge clk);
        chk("l1 valid c2", ib.resp_valid, 0);
        chk("l1 ready c2", ib.req_ready,  1);
        @(negedge clk);
        ib.req_valid = 1'b0;
        chk("l1 valid c3", ib.resp_valid, 1);
        chk("l1 inst c3",  ib.resp_inst,  32'hAAAA_0001);
        @(negedge clk);
        chk("l1 idle c4", ib.resp_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
